ft_ckpt_mem: RTL and testbench

Checkpoint memory responder for the fault-tolerant lockstep core. It sits behind the FTM data port and answers the Ibex LSU data protocol (req/gnt/rvalid/err) that core 0 drives during recovery. While the cores run normally it shadows every committed register-file write and the committed PC. During recovery the debug-mode routine at the halt address reads the shadow state back over the bus, and may patch it.

---
 rtl/ft_ckpt_mem.sv | 153 +++++++++++++++
 tb/tb_ft_ckpt_mem.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ft_ckpt_mem.sv
// Checkpoint memory for lockstep recovery: shadows committed regfile writes and
// the committed PC, and serves them over an Ibex-style req/gnt/rvalid/err port.
module ft_ckpt_mem #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned GNT_DELAY = 0
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        ckpt_en_i,
  input  logic        ckpt_we_i,
  input  logic [4:0]  ckpt_waddr_i,
  input  logic [31:0] ckpt_wdata_i,
  input  logic [31:0] pc_i,
  input  logic        data_req_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o,
  output logic [31:0] ckpt_pc_o
);
  // Handshake: a request is accepted on the edge where data_req_i && data_gnt_o;
  // exactly one data_rvalid_o pulse follows one cycle later with rdata/err.
  typedef enum logic {IDLE, WAIT} state_e;

  localparam logic [1:0] DELAY      = GNT_DELAY[1:0];
  localparam logic [5:0] IDX_PC     = 6'd32;
  localparam logic [5:0] IDX_STATUS = 6'd33;

  state_e      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] shadow_q [32];
  logic [31:0] shadow_d [32];
  logic [31:0] pc_q, pc_d;
  logic        rvalid_q, rvalid_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic        gnt;
  logic [5:0]  idx;
  logic        mapped;
  logic        accept;
  logic        bus_wr;
  logic [31:0] rd_word;
  logic        unused_addr_lsb;

  assign unused_addr_lsb = ^data_addr_i[1:0];

  function automatic logic [31:0] merge_be(input logic [31:0] old_w,
                                           input logic [31:0] new_w,
                                           input logic [3:0]  be);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
    end
    return r;
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gnt     = 1'b0;
    if (GNT_DELAY == 0) begin
      gnt = data_req_i;
    end else begin
      case (state_q)
        IDLE: begin
          if (data_req_i) begin
            state_d = WAIT;
            cnt_d   = 2'd1;
          end
        end
        WAIT: begin
          // A dropped request abandons the wait; the next one starts over.
          if (!data_req_i) begin
            state_d = IDLE;
            cnt_d   = 2'd0;
          end else if (cnt_q == DELAY) begin
            gnt     = 1'b1;
            state_d = IDLE;
            cnt_d   = 2'd0;
          end else begin
            cnt_d = cnt_q + 2'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign idx    = data_addr_i[7:2];
  assign mapped = (data_addr_i[31:8] == BASE_ADDR[31:8]) && (idx <= IDX_STATUS);
  assign accept = data_req_i && gnt;
  assign bus_wr = accept && mapped && data_we_i;

  always_comb begin
    rd_word = 32'h0;
    if (idx < IDX_PC)           rd_word = shadow_q[idx[4:0]];
    else if (idx == IDX_PC)     rd_word = pc_q;
    else if (idx == IDX_STATUS) rd_word = {31'b0, ckpt_en_i};
  end

  always_comb begin
    shadow_d = shadow_q;
    pc_d     = pc_q;
    if (ckpt_en_i && ckpt_we_i) begin
      if (ckpt_waddr_i != 5'd0) shadow_d[ckpt_waddr_i] = ckpt_wdata_i;
      pc_d = pc_i;
    end
    // Applied after the commit so a same-word bus write wins for the whole word.
    if (bus_wr) begin
      if (idx < IDX_PC) begin
        if (idx[4:0] != 5'd0) shadow_d[idx[4:0]] = merge_be(shadow_q[idx[4:0]], data_wdata_i, data_be_i);
      end else if (idx == IDX_PC) begin
        pc_d = merge_be(pc_q, data_wdata_i, data_be_i);
      end
    end
    rvalid_d = accept;
    rdata_d  = (accept && mapped && !data_we_i) ? rd_word : 32'h0;
    err_d    = accept && !mapped;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      cnt_q    <= 2'd0;
      pc_q     <= 32'h0;
      rvalid_q <= 1'b0;
      rdata_q  <= 32'h0;
      err_q    <= 1'b0;
      for (int i = 0; i < 32; i++) shadow_q[i] <= 32'h0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pc_q     <= pc_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      shadow_q <= shadow_d;
    end
  end

  assign data_gnt_o    = gnt;
  assign data_rvalid_o = rvalid_q;
  assign data_rdata_o  = rdata_q;
  assign data_err_o    = err_q;
  assign ckpt_pc_o     = pc_q;

endmodule

// File: tb/tb_ft_ckpt_mem.sv
// Bench for ft_ckpt_mem: two instances (no grant delay / delay 2) checked every
// cycle against a word-level model of the checkpoint map and grant timing.
`timescale 1ns/1ps
module tb_ft_ckpt_mem;
  localparam logic [31:0] BASE0 = 32'h0000_0000;
  localparam logic [31:0] BASE1 = 32'h8000_0200;
  localparam int D0 = 0;
  localparam int D1 = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ckpt_en, ckpt_we;
  logic [4:0]  ckpt_waddr;
  logic [31:0] ckpt_wdata, pc;
  logic        req [2];
  logic        gnt [2];
  logic        rvalid [2];
  logic        we [2];
  logic [3:0]  be [2];
  logic [31:0] addr [2];
  logic [31:0] wdata [2];
  logic [31:0] rdata [2];
  logic        err [2];
  logic [31:0] ckpt_pc [2];

  int errors = 0;
  int checks = 0;

  // model state
  logic [31:0] m_reg [2][32];
  logic [31:0] m_pc [2];
  int          run [2];
  logic [33:0] exp_q[$];   // {instance, err, rdata}

  always #5 clk = ~clk;

  ft_ckpt_mem #(.BASE_ADDR(BASE0), .GNT_DELAY(D0)) u_dut0 (
    .clk_i(clk), .rst_ni(rst_n), .ckpt_en_i(ckpt_en), .ckpt_we_i(ckpt_we),
    .ckpt_waddr_i(ckpt_waddr), .ckpt_wdata_i(ckpt_wdata), .pc_i(pc),
    .data_req_i(req[0]), .data_gnt_o(gnt[0]), .data_rvalid_o(rvalid[0]),
    .data_we_i(we[0]), .data_be_i(be[0]), .data_addr_i(addr[0]),
    .data_wdata_i(wdata[0]), .data_rdata_o(rdata[0]), .data_err_o(err[0]),
    .ckpt_pc_o(ckpt_pc[0])
  );

  ft_ckpt_mem #(.BASE_ADDR(BASE1), .GNT_DELAY(D1)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n), .ckpt_en_i(ckpt_en), .ckpt_we_i(ckpt_we),
    .ckpt_waddr_i(ckpt_waddr), .ckpt_wdata_i(ckpt_wdata), .pc_i(pc),
    .data_req_i(req[1]), .data_gnt_o(gnt[1]), .data_rvalid_o(rvalid[1]),
    .data_we_i(we[1]), .data_be_i(be[1]), .data_addr_i(addr[1]),
    .data_wdata_i(wdata[1]), .data_rdata_o(rdata[1]), .data_err_o(err[1]),
    .ckpt_pc_o(ckpt_pc[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] apply_be(input logic [31:0] o, input logic [31:0] n,
                                           input logic [3:0] b);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++) if (b[i]) r[8*i +: 8] = n[8*i +: 8];
    return r;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 32; i++) m_reg[k][i] = 32'h0;
      m_pc[k] = 32'h0;
      run[k] = 0;
    end
    exp_q.delete();
  endtask

  // Checks the outputs of instance k for this cycle, then advances the model
  // by the effect of the coming rising edge.
  task automatic model_step(input int k);
    logic [31:0] base, rd_v, bus_v;
    logic [5:0]  idx;
    logic        mapped, eg, has;
    logic [33:0] e;
    int          dly;
    base = (k == 0) ? BASE0 : BASE1;
    dly  = (k == 0) ? D0 : D1;
    has  = (exp_q.size() > 0) && (exp_q[0][33] == k[0]);
    chk($sformatf("rvalid%0d", k), 32'(rvalid[k]), 32'(has));
    if (has) begin
      e = exp_q.pop_front();
      chk($sformatf("rdata%0d", k), rdata[k], e[31:0]);
      chk($sformatf("err%0d", k), 32'(err[k]), 32'(e[32]));
    end else begin
      chk($sformatf("rdata_idle%0d", k), rdata[k], 32'h0);
      chk($sformatf("err_idle%0d", k), 32'(err[k]), 32'h0);
    end
    chk($sformatf("ckpt_pc%0d", k), ckpt_pc[k], m_pc[k]);

    // grant after dly+1 consecutive cycles of request
    if (req[k]) run[k]++; else run[k] = 0;
    eg = req[k] && (run[k] == dly + 1);
    chk($sformatf("gnt%0d", k), 32'(gnt[k]), 32'(eg));

    idx    = addr[k][7:2];
    mapped = (addr[k][31:8] == base[31:8]) && (idx <= 6'd33);
    rd_v   = 32'h0;
    if (idx < 6'd32)       rd_v = (idx == 6'd0) ? 32'h0 : m_reg[k][idx[4:0]];
    else if (idx == 6'd32) rd_v = m_pc[k];
    else if (idx == 6'd33) rd_v = {31'b0, ckpt_en};
    bus_v = apply_be((idx == 6'd32) ? m_pc[k] : m_reg[k][idx[4:0]], wdata[k], be[k]);

    if (ckpt_en && ckpt_we) begin
      if (ckpt_waddr != 5'd0) m_reg[k][ckpt_waddr] = ckpt_wdata;
      m_pc[k] = pc;
    end
    if (eg) begin
      run[k] = 0;
      if (!mapped) begin
        exp_q.push_back({k[0], 1'b1, 32'h0});
      end else if (we[k]) begin
        exp_q.push_back({k[0], 1'b0, 32'h0});
        if (idx >= 6'd1 && idx <= 6'd31) m_reg[k][idx[4:0]] = bus_v;
        else if (idx == 6'd32)           m_pc[k] = bus_v;
      end else begin
        exp_q.push_back({k[0], 1'b0, rd_v});
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("rst_gnt%0d", k), 32'(gnt[k]), 32'h0);
        chk($sformatf("rst_rvalid%0d", k), 32'(rvalid[k]), 32'h0);
        chk($sformatf("rst_rdata%0d", k), rdata[k], 32'h0);
        chk($sformatf("rst_err%0d", k), 32'(err[k]), 32'h0);
        chk($sformatf("rst_pc%0d", k), ckpt_pc[k], 32'h0);
      end
      model_clear();
    end else begin
      model_step(0);
      model_step(1);
    end
  end

  // driver tasks
  task automatic bus_op(input int k, input logic w, input logic [3:0] b,
                        input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output logic e, output int ncyc);
    logic got;
    @(posedge clk); #1;
    req[k] = 1'b1; we[k] = w; be[k] = b; addr[k] = a; wdata[k] = d;
    got = 1'b0;
    ncyc = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      ncyc++;
      if (gnt[k]) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL gnt_timeout%0d: got no grant expected grant within 20 cycles", k);
    end
    @(posedge clk); #1;
    req[k] = 1'b0;
    @(negedge clk);
    rd = rdata[k];
    e  = err[k];
  endtask

  task automatic commit(input logic [4:0] a, input logic [31:0] d, input logic [31:0] p);
    @(posedge clk); #1;
    ckpt_we = 1'b1; ckpt_waddr = a; ckpt_wdata = d; pc = p;
    @(posedge clk); #1;
    ckpt_we = 1'b0;
  endtask

  task automatic rand_ops(input int k, input int n);
    for (int i = 0; i < n; i++) begin
      logic [31:0] a, rd;
      logic        e;
      int          c;
      a = ((k == 0) ? BASE0 : BASE1) | (32'($urandom_range(0, 35)) << 2) | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) a = $urandom;
      bus_op(k, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), a, $urandom, rd, e, c);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end
  endtask

  task automatic rand_commits(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      ckpt_en    = ($urandom_range(0, 3) != 0);
      ckpt_we    = 1'($urandom_range(0, 1));
      ckpt_waddr = 5'($urandom_range(0, 31));
      ckpt_wdata = $urandom;
      pc         = $urandom;
    end
    @(posedge clk); #1;
    ckpt_we = 1'b0;
    ckpt_en = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test expected finish before 500us");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic        e;
    int          c;
    ckpt_en = 1'b0; ckpt_we = 1'b0; ckpt_waddr = 5'd0; ckpt_wdata = 32'h0; pc = 32'h0;
    for (int k = 0; k < 2; k++) begin
      req[k] = 1'b0; we[k] = 1'b0; be[k] = 4'h0; addr[k] = 32'h0; wdata[k] = 32'h0;
    end
    model_clear();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("reset_pc", ckpt_pc[0], 32'h0);
    ckpt_en = 1'b1;

    // commit then read back through the bus
    commit(5'd5, 32'hDEAD_BEEF, 32'h0000_0084);
    chk("pc_after_commit", ckpt_pc[0], 32'h0000_0084);
    bus_op(0, 1'b0, 4'hF, BASE0 + 32'h14, 32'h0, rd, e, c);
    chk("x5_read", rd, 32'hDEAD_BEEF);
    chk("x5_err", 32'(e), 32'h0);
    chk("d0_gnt_cycle", 32'(c), 32'd1);
    bus_op(0, 1'b0, 4'hF, BASE0 + 32'h80, 32'h0, rd, e, c);
    chk("pc_read", rd, 32'h0000_0084);

    // byte-lane write and x0
    commit(5'd7, 32'hFFFF_FFFF, 32'h0000_0088);
    bus_op(0, 1'b1, 4'b0011, BASE0 + 32'h1C, 32'h1234_5678, rd, e, c);
    chk("write_resp", rd, 32'h0);
    bus_op(0, 1'b0, 4'hF, BASE0 + 32'h1C, 32'h0, rd, e, c);
    chk("x7_partial", rd, 32'hFFFF_5678);
    bus_op(0, 1'b1, 4'hF, BASE0, 32'hAAAA_5555, rd, e, c);
    bus_op(0, 1'b0, 4'hF, BASE0, 32'h0, rd, e, c);
    chk("x0_read", rd, 32'h0);

    // unmapped accesses
    bus_op(0, 1'b0, 4'hF, BASE0 + 32'h88, 32'h0, rd, e, c);
    chk("idx34_err", 32'(e), 32'h1);
    chk("idx34_rdata", rd, 32'h0);
    bus_op(0, 1'b0, 4'hF, 32'h0000_1000, 32'h0, rd, e, c);
    chk("far_err", 32'(e), 32'h1);
    bus_op(0, 1'b0, 4'hF, BASE0 + 32'h14, 32'h0, rd, e, c);
    chk("x5_after_err", rd, 32'hDEAD_BEEF);

    // commit and bus write to x3 on the same edge
    @(posedge clk); #1;
    ckpt_we = 1'b1; ckpt_waddr = 5'd3; ckpt_wdata = 32'h1; pc = 32'h0000_0090;
    req[0] = 1'b1; we[0] = 1'b1; be[0] = 4'hF; addr[0] = BASE0 + 32'h0C; wdata[0] = 32'h2;
    @(posedge clk); #1;
    ckpt_we = 1'b0; req[0] = 1'b0;
    chk("collide_pc", ckpt_pc[0], 32'h0000_0090);
    bus_op(0, 1'b0, 4'hF, BASE0 + 32'h0C, 32'h0, rd, e, c);
    chk("collide_x3", rd, 32'h2);

    // frozen commits and status word
    ckpt_en = 1'b0;
    commit(5'd3, 32'h9, 32'h0000_0094);
    bus_op(0, 1'b0, 4'hF, BASE0 + 32'h0C, 32'h0, rd, e, c);
    chk("frozen_x3", rd, 32'h2);
    bus_op(0, 1'b0, 4'hF, BASE0 + 32'h84, 32'h0, rd, e, c);
    chk("status_frozen", rd, 32'h0);
    ckpt_en = 1'b1;
    bus_op(0, 1'b0, 4'hF, BASE0 + 32'h84, 32'h0, rd, e, c);
    chk("status_en", rd, 32'h1);

    // delayed-grant instance: same commit stream, no bus write to x3
    bus_op(1, 1'b0, 4'hF, BASE1 + 32'h0C, 32'h0, rd, e, c);
    chk("d2_x3", rd, 32'h1);
    chk("d2_gnt_cycle", 32'(c), 32'd3);
    @(posedge clk); #1;
    req[1] = 1'b1; we[1] = 1'b0; addr[1] = BASE1 + 32'h14;
    @(negedge clk);
    chk("drop_gnt", 32'(gnt[1]), 32'h0);
    @(posedge clk); #1;
    req[1] = 1'b0;
    repeat (3) @(posedge clk);
    bus_op(1, 1'b0, 4'hF, BASE1 + 32'h14, 32'h0, rd, e, c);
    chk("d2_after_drop", rd, 32'hDEAD_BEEF);
    chk("d2_after_drop_cycle", 32'(c), 32'd3);

    // randomized traffic on both instances under random commits
    fork
      rand_ops(0, 60);
      rand_ops(1, 40);
      rand_commits(250);
    join

    // reset in the cycle after a grant
    @(posedge clk); #1;
    req[0] = 1'b1; we[0] = 1'b0; addr[0] = BASE0 + 32'h14;
    @(negedge clk);
    chk("pre_rst_gnt", 32'(gnt[0]), 32'h1);
    @(posedge clk); #1;
    req[0] = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_no_rvalid", 32'(rvalid[0]), 32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i <= 32; i++) begin
      bus_op(0, 1'b0, 4'hF, BASE0 + 32'(i * 4), 32'h0, rd, e, c);
      chk($sformatf("post_rst_word%0d", i), rd, 32'h0);
    end
    bus_op(1, 1'b0, 4'hF, BASE1 + 32'h80, 32'h0, rd, e, c);
    chk("post_rst_pc1", rd, 32'h0);

    repeat (3) @(posedge clk);
    chk("exp_q_empty", 32'(exp_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
